// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional build macro DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with div_by_zero=1.
module seq_divider #(
  parameter int DW = 6,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and out_valid holds until out_ready.
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [VW-1:0] divisor_q, divisor_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The partial remainder is always below the divisor, so VW bits hold it; the shifted
  // value needs one extra bit before the compare.
  logic [VW:0] shifted;
  logic        fits;

  always_comb begin
    shifted = {rem_q, dividend_q[cnt_q]};
    fits    = (shifted >= {1'b0, divisor_q});
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d      = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          quotient_d = '0;
          rem_d      = '0;
          cnt_d      = CW'(DW - 1);
          state_d    = CALC;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d      = (divisor == '0);
          if (divisor == '0) begin
            quotient_d = '1;
            rem_d      = dividend[VW-1:0];
            state_d    = DONE;
          end
`endif
        end
      end
      CALC: begin
        // Subtraction is done modulo 2^VW; the true difference is below the divisor.
        rem_d             = fits ? (shifted[VW-1:0] - divisor_q) : shifted[VW-1:0];
        quotient_d[cnt_q] = fits;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quotient_q <= quotient_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = rem_q;

endmodule
